// File: rtl/text_pkg.sv
// Shared constants and types for the text-buffer write sequencer:
// ASCII control codes, FSM state encoding and cursor command bundle.
package text_pkg;

    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_FF        = 8'h0C;
    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One-hot cursor command; at most one field is set per cycle.
    typedef struct packed {
        logic adv;
        logic bs;
        logic cr;
        logic lf;
        logic home;
    } cursor_cmd_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_PRINT_MIN) && (b <= ASCII_PRINT_MAX);
    endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Byte-input and RAM-write-port bundle of text_buffer_ctrl.
// master = byte source / observer side, slave = the controller.
interface text_buffer_ctrl_if #(
    parameter int COLS = 32,
    parameter int ROWS = 4
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             clr;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_data;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             busy;
    logic             dropped;

    modport master (
        output in_data, in_valid, clr,
        input  in_ready, wr_en, wr_row, wr_col, wr_data,
               cur_row, cur_col, busy, dropped
    );

    modport slave (
        input  in_data, in_valid, clr,
        output in_ready, wr_en, wr_row, wr_col, wr_data,
               cur_row, cur_col, busy, dropped
    );

endinterface

// File: rtl/text_cursor.sv
// Row/column write cursor with wrap rules; also exposes the backspace
// target so the caller can blank that cell on the same edge.
module text_cursor
    import text_pkg::*;
#(
    parameter  int COLS  = 32,
    parameter  int ROWS  = 4,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cursor_cmd_t      cmd,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] bs_row,
    output logic [COL_W-1:0] bs_col,
    output logic             bs_move
);

    logic [ROW_W-1:0] row_reg, row_next;
    logic [COL_W-1:0] col_reg, col_next;

    always_comb begin
        // Dimensions are powers of two, so plain +/-1 gives the wrap.
        bs_move  = (col_reg != '0) || (row_reg != '0);
        bs_col   = col_reg - COL_W'(1);
        bs_row   = (col_reg == '0) ? row_reg - ROW_W'(1) : row_reg;
        row_next = row_reg;
        col_next = col_reg;
        if (cmd.home) begin
            row_next = '0;
            col_next = '0;
        end else if (cmd.adv) begin
            col_next = col_reg + COL_W'(1);
            if (col_reg == COL_W'(COLS - 1)) begin
                row_next = row_reg + ROW_W'(1);
            end
        end else if (cmd.bs) begin
            if (bs_move) begin
                row_next = bs_row;
                col_next = bs_col;
            end
        end else if (cmd.cr) begin
            col_next = '0;
        end else if (cmd.lf) begin
            row_next = row_reg + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row = row_reg;
    assign col = col_reg;

endmodule

// File: rtl/text_buffer_ctrl.sv
// Write-side sequencer for the VGA text RAM: accepts UART bytes, handles
// CR/LF/BS/FF and runs the fill-character clear. Optional macro:
// TEXT_BUFFER_CTRL_CLEAR_ON_WRAP_EN (clear after writing the last cell).
module text_buffer_ctrl
    import text_pkg::*;
#(
    parameter int         COLS      = 32,
    parameter int         ROWS      = 4,
    parameter logic [7:0] FILL_CHAR = ASCII_SPACE
) (
    input logic               clk,
    input logic               reset,
    text_buffer_ctrl_if.slave bus
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CELLS  = ROWS * COLS;
    localparam int FILL_W = $clog2(CELLS) + 1;

    state_t           state_reg, state_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic             wr_en_reg, wr_en_next;
    logic [ROW_W-1:0] wr_row_reg, wr_row_next;
    logic [COL_W-1:0] wr_col_reg, wr_col_next;
    logic [7:0]       wr_data_reg, wr_data_next;
    logic             in_ready_reg, in_ready_next;
    logic             busy_reg, busy_next;
    logic             dropped_reg, dropped_next;

    cursor_cmd_t      cmd;
    logic [ROW_W-1:0] cur_row, bs_row;
    logic [COL_W-1:0] cur_col, bs_col;
    logic             bs_move;

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd),
        .row     (cur_row),
        .col     (cur_col),
        .bs_row  (bs_row),
        .bs_col  (bs_col),
        .bs_move (bs_move)
    );

    always_comb begin
        state_next   = state_reg;
        fill_next    = fill_reg;
        wr_en_next   = 1'b0;
        wr_row_next  = wr_row_reg;
        wr_col_next  = wr_col_reg;
        wr_data_next = wr_data_reg;
        cmd          = '0;
        // A strobe is lost when nobody is accepting, or when clr wins.
        dropped_next = bus.in_valid && (!in_ready_reg || bus.clr);
        case (state_reg)
            IDLE: begin
                if (bus.clr) begin
                    state_next = CLEAR;
                    fill_next  = '0;
                end else if (bus.in_valid) begin
                    if (is_printable(bus.in_data)) begin
                        wr_en_next   = 1'b1;
                        wr_row_next  = cur_row;
                        wr_col_next  = cur_col;
                        wr_data_next = bus.in_data;
                        cmd.adv      = 1'b1;
`ifdef TEXT_BUFFER_CTRL_CLEAR_ON_WRAP_EN
                        if (cur_row == ROW_W'(ROWS - 1) && cur_col == COL_W'(COLS - 1)) begin
                            state_next = CLEAR;
                            fill_next  = '0;
                        end
`else
`endif
                    end else begin
                        case (bus.in_data)
                            ASCII_CR: cmd.cr = 1'b1;
                            ASCII_LF: cmd.lf = 1'b1;
                            ASCII_BS: begin
                                cmd.bs = 1'b1;
                                if (bs_move) begin
                                    wr_en_next   = 1'b1;
                                    wr_row_next  = bs_row;
                                    wr_col_next  = bs_col;
                                    wr_data_next = FILL_CHAR;
                                end
                            end
                            ASCII_FF: begin
                                state_next = CLEAR;
                                fill_next  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                // fill_reg == CELLS marks the idle cycle after the last write.
                if (fill_reg == FILL_W'(CELLS)) begin
                    state_next = IDLE;
                    cmd.home   = 1'b1;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_row_next  = fill_reg[COL_W +: ROW_W];
                    wr_col_next  = fill_reg[COL_W-1:0];
                    wr_data_next = FILL_CHAR;
                    fill_next    = fill_reg + FILL_W'(1);
                end
            end
            default: state_next = CLEAR;
        endcase
        in_ready_next = (state_next == IDLE);
        busy_next     = (state_next == CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= CLEAR;
            fill_reg     <= '0;
            wr_en_reg    <= 1'b0;
            wr_row_reg   <= '0;
            wr_col_reg   <= '0;
            wr_data_reg  <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            dropped_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_reg     <= fill_next;
            wr_en_reg    <= wr_en_next;
            wr_row_reg   <= wr_row_next;
            wr_col_reg   <= wr_col_next;
            wr_data_reg  <= wr_data_next;
            in_ready_reg <= in_ready_next;
            busy_reg     <= busy_next;
            dropped_reg  <= dropped_next;
        end
    end

    assign bus.wr_en    = wr_en_reg;
    assign bus.wr_row   = wr_row_reg;
    assign bus.wr_col   = wr_col_reg;
    assign bus.wr_data  = wr_data_reg;
    assign bus.in_ready = in_ready_reg;
    assign bus.busy     = busy_reg;
    assign bus.dropped  = dropped_reg;
    assign bus.cur_row  = cur_row;
    assign bus.cur_col  = cur_col;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: table-driven byte vectors plus
// hand-written clear, full-screen and reset-during-clear sequences.
module tb_text_buffer_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    text_buffer_ctrl_if #(.COLS(32), .ROWS(4)) bus_if ();

    text_buffer_ctrl #(.COLS(32), .ROWS(4), .FILL_CHAR(8'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       clr;
        logic       exp_wr;
        int         exp_row;
        int         exp_col;
        logic [7:0] exp_data;
        int         exp_cur_row;
        int         exp_cur_col;
        logic       exp_drop;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_wr(input int r, input int c, input int d);
        return (r << 16) | (c << 8) | d;
    endfunction

    function automatic int dut_wr();
        return pack_wr(int'(bus_if.wr_row), int'(bus_if.wr_col), int'(bus_if.wr_data));
    endfunction

    task automatic check_reset_values();
        chk("rst_wr_en", int'(bus_if.wr_en), 0);
        chk("rst_wr_pos_data", dut_wr(), 0);
        chk("rst_cur_row", int'(bus_if.cur_row), 0);
        chk("rst_cur_col", int'(bus_if.cur_col), 0);
        chk("rst_dropped", int'(bus_if.dropped), 0);
        chk("rst_in_ready", int'(bus_if.in_ready), 0);
        chk("rst_busy", int'(bus_if.busy), 1);
    endtask

    // Follows a clear to completion, checking every fill write in order.
    task automatic wait_clear(input string tag);
        int n = 0;
        bit done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (bus_if.wr_en) begin
                chk({tag, "_write"}, dut_wr(), pack_wr(n / 32, n % 32, 8'h20));
                n++;
            end
            if (bus_if.in_ready) done = 1;
        end
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_count"}, n, 128);
        chk({tag, "_busy"}, int'(bus_if.busy), 0);
        chk({tag, "_cur"}, pack_wr(int'(bus_if.cur_row), int'(bus_if.cur_col), 0), 0);
        $display("clear %s: %0d fill writes", tag, n);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus_if.in_data  = 8'h00;
        bus_if.in_valid = 1'b0;
        bus_if.clr      = 1'b0;

        //          data  v  clr wr row col wdata  cr cc drop busy
        tbl[0]  = '{8'h48, 1, 0, 1, 0, 0,  8'h48, 0, 1,  0, 0};
        tbl[1]  = '{8'h69, 1, 0, 1, 0, 1,  8'h69, 0, 2,  0, 0};
        tbl[2]  = '{8'h00, 1, 0, 0, 0, 0,  8'h00, 0, 2,  0, 0};
        tbl[3]  = '{8'h0D, 1, 0, 0, 0, 0,  8'h00, 0, 0,  0, 0};
        tbl[4]  = '{8'h08, 1, 0, 0, 0, 0,  8'h00, 0, 0,  0, 0};
        tbl[5]  = '{8'h0A, 1, 0, 0, 0, 0,  8'h00, 1, 0,  0, 0};
        tbl[6]  = '{8'h08, 1, 0, 1, 0, 31, 8'h20, 0, 31, 0, 0};
        tbl[7]  = '{8'h5A, 1, 0, 1, 0, 31, 8'h5A, 1, 0,  0, 0};
        tbl[8]  = '{8'h7F, 1, 0, 0, 0, 0,  8'h00, 1, 0,  0, 0};
        tbl[9]  = '{8'h0A, 1, 0, 0, 0, 0,  8'h00, 2, 0,  0, 0};
        tbl[10] = '{8'h7E, 1, 0, 1, 2, 0,  8'h7E, 2, 1,  0, 0};
        tbl[11] = '{8'h20, 1, 0, 1, 2, 1,  8'h20, 2, 2,  0, 0};
        tbl[12] = '{8'h08, 1, 0, 1, 2, 1,  8'h20, 2, 1,  0, 0};
        tbl[13] = '{8'h0D, 1, 0, 0, 0, 0,  8'h00, 2, 0,  0, 0};
        tbl[14] = '{8'h0A, 1, 0, 0, 0, 0,  8'h00, 3, 0,  0, 0};
        tbl[15] = '{8'h0A, 1, 0, 0, 0, 0,  8'h00, 0, 0,  0, 0};
        tbl[16] = '{8'h51, 0, 0, 0, 0, 0,  8'h00, 0, 0,  0, 0};
        tbl[17] = '{8'h42, 1, 1, 0, 0, 0,  8'h00, 0, 0,  1, 1};

        // Power-on: reset held, then released into the automatic clear.
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        wait_clear("poweron");
        chk("poweron_in_ready", int'(bus_if.in_ready), 1);

        // Byte vectors; the last one (clr + byte) starts a clear.
        for (int i = 0; i < 18; i++) begin
            bus_if.in_data  = tbl[i].data;
            bus_if.in_valid = tbl[i].valid;
            bus_if.clr      = tbl[i].clr;
            @(negedge clk);
            chk("vec_wr_en", int'(bus_if.wr_en), int'(tbl[i].exp_wr));
            if (tbl[i].exp_wr)
                chk("vec_write", dut_wr(), pack_wr(tbl[i].exp_row, tbl[i].exp_col, int'(tbl[i].exp_data)));
            chk("vec_cursor", pack_wr(int'(bus_if.cur_row), int'(bus_if.cur_col), 0),
                pack_wr(tbl[i].exp_cur_row, tbl[i].exp_cur_col, 0));
            chk("vec_dropped", int'(bus_if.dropped), int'(tbl[i].exp_drop));
            chk("vec_busy", int'(bus_if.busy), int'(tbl[i].exp_busy));
            $display("vec %0d: data=%02h valid=%0b clr=%0b wr_en=%0b cur=(%0d,%0d) dropped=%0b",
                     i, tbl[i].data, tbl[i].valid, tbl[i].clr, bus_if.wr_en,
                     bus_if.cur_row, bus_if.cur_col, bus_if.dropped);
        end
        bus_if.in_valid = 1'b0;
        bus_if.clr      = 1'b0;
        wait_clear("clr_req");

        // Fill every cell back to back; the cursor wraps to the origin.
        for (int i = 0; i < 128; i++) begin
            bus_if.in_data  = 8'h21 + 8'(i % 94);
            bus_if.in_valid = 1'b1;
            @(negedge clk);
            chk("full_wr_en", int'(bus_if.wr_en), 1);
            chk("full_write", dut_wr(), pack_wr(i / 32, i % 32, 8'h21 + (i % 94)));
        end
        bus_if.in_valid = 1'b0;
        chk("full_cursor", pack_wr(int'(bus_if.cur_row), int'(bus_if.cur_col), 0), 0);
        $display("full screen: 128 bytes written, cursor=(%0d,%0d)", bus_if.cur_row, bus_if.cur_col);
`ifdef TEXT_BUFFER_CTRL_CLEAR_ON_WRAP_EN
        wait_clear("wrap");
`else
        @(negedge clk);
        chk("full_no_clear_busy", int'(bus_if.busy), 0);
        chk("full_no_clear_ready", int'(bus_if.in_ready), 1);
        chk("full_no_clear_wr_en", int'(bus_if.wr_en), 0);
`endif

        // Move the cursor off the origin so the reset check is meaningful.
        bus_if.in_data  = 8'h78;
        bus_if.in_valid = 1'b1;
        @(negedge clk);
        chk("pre_ff_write", dut_wr(), pack_wr(0, 0, 8'h78));
        bus_if.in_data = 8'h0C;
        @(negedge clk);
        chk("ff_busy", int'(bus_if.busy), 1);
        chk("ff_wr_en", int'(bus_if.wr_en), 0);
        chk("ff_cur_col", int'(bus_if.cur_col), 1);
        // Byte during the clear is dropped and never written.
        bus_if.in_data = 8'h41;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("drop_pulse", int'(bus_if.dropped), 1);
        chk("drop_clear_write0", dut_wr(), pack_wr(0, 0, 8'h20));
        // A clr pulse mid-clear must not restart the fill sequence.
        for (int k = 1; k < 50; k++) begin
            bus_if.clr = (k == 10);
            @(negedge clk);
            chk("midclr_write", dut_wr(), pack_wr(k / 32, k % 32, 8'h20));
            if (k == 1) chk("drop_one_cycle", int'(bus_if.dropped), 0);
        end
        bus_if.clr = 1'b0;
        $display("clear interrupted by reset at fill cycle 50");
        reset = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_clear("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
